// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// - IO page numbers, compared against address bits [31:12]
// - funct3 encodings for the supported access types
// - access-size and target-select enums
// - helpers: funct3 -> size, and size/offset -> byte enables
package lsu_pkg;

   localparam logic [19:0] PAGE_LEDR   = 20'h10000;
   localparam logic [19:0] PAGE_LEDG   = 20'h10001;
   localparam logic [19:0] PAGE_HEX_LO = 20'h10002;
   localparam logic [19:0] PAGE_HEX_HI = 20'h10003;
   localparam logic [19:0] PAGE_LCD    = 20'h10004;
   localparam logic [19:0] PAGE_SW     = 20'h10010;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   typedef enum logic [1:0] {
      SIZE_BYTE,
      SIZE_HALF,
      SIZE_WORD,
      SIZE_BAD
   } size_e;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_DMEM,
      SEL_LEDR,
      SEL_LEDG,
      SEL_HEX_LO,
      SEL_HEX_HI,
      SEL_LCD,
      SEL_SW
   } sel_e;

   function automatic size_e f3_size(input logic [2:0] f3);
      case (f3)
         F3_LB, F3_LBU: return SIZE_BYTE;
         F3_LH, F3_LHU: return SIZE_HALF;
         F3_LW:         return SIZE_WORD;
         default:       return SIZE_BAD;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input size_e s, input logic [1:0] off);
      case (s)
         SIZE_BYTE: return 4'b0001 << off;
         SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
         SIZE_WORD: return 4'b1111;
         default:   return 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/lsu_dmem.sv
// Data memory: word-organised array with 4 byte lanes.
// Synchronous byte-enabled write, asynchronous (combinational) read.
// Contents are deliberately not reset.
// Ports:
//   i_clk        clock
//   i_wr_en      write this cycle (already qualified by the caller)
//   i_word_addr  word index
//   i_be         byte-lane enables
//   i_wdata      lane-aligned write data
//   o_rdata      word at i_word_addr
module dmem #(
   parameter int DMEM_BYTES = 8192,
   parameter int AW         = $clog2(DMEM_BYTES)
) (
   input  logic          i_clk,
   input  logic          i_wr_en,
   input  logic [AW-3:0] i_word_addr,
   input  logic [3:0]    i_be,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);

   logic [31:0] r_mem [DMEM_BYTES/4];

   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         for (int i = 0; i < 4; i++) begin
            if (i_be[i]) r_mem[i_word_addr][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   assign o_rdata = r_mem[i_word_addr];

endmodule

// File: rtl/lsu.sv
// Load/store unit with memory-mapped IO.
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_lsu_addr, i_st_data     byte address and store data
//   i_lsu_wren, i_funct3      store request, access size/signedness
//   o_ld_data, o_misaligned   zero-latency load result, misalignment flag
//   i_io_sw                   asynchronous switch inputs (synchronised)
//   o_io_ledr/ledg/lcd        32-bit IO registers
//   o_io_hex0..7              7-bit seven-segment registers
module lsu
   import lsu_pkg::*;
#(
   parameter int DMEM_BYTES = 8192
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_lsu_addr,
   input  logic [31:0] i_st_data,
   input  logic        i_lsu_wren,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_ld_data,
   output logic        o_misaligned,
   input  logic [31:0] i_io_sw,
   output logic [31:0] o_io_ledr,
   output logic [31:0] o_io_ledg,
   output logic [6:0]  o_io_hex0,
   output logic [6:0]  o_io_hex1,
   output logic [6:0]  o_io_hex2,
   output logic [6:0]  o_io_hex3,
   output logic [6:0]  o_io_hex4,
   output logic [6:0]  o_io_hex5,
   output logic [6:0]  o_io_hex6,
   output logic [6:0]  o_io_hex7,
   output logic [31:0] o_io_lcd
);

   localparam int AW = $clog2(DMEM_BYTES);

   size_e       w_size;
   sel_e        w_sel;
   logic        w_illegal;
   logic        w_misaligned;
   logic        w_access_ok;
   logic        w_store;
   logic        w_dmem_we;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [31:0] w_dmem_rdata;
   logic [31:0] w_rword;
   logic [15:0] w_lane;
   logic [31:0] w_ld;

   logic [31:0] r_ledr;
   logic [31:0] r_ledg;
   logic [31:0] r_lcd;
   logic [6:0]  r_hex [8];
   logic [31:0] r_sw_meta;
   logic [31:0] r_sw_sync;

   assign w_size       = f3_size(i_funct3);
   assign w_illegal    = (w_size == SIZE_BAD);
   assign w_misaligned = ((w_size == SIZE_HALF) && i_lsu_addr[0]) ||
                         ((w_size == SIZE_WORD) && (i_lsu_addr[1:0] != 2'b00));
   assign w_access_ok  = !w_illegal && !w_misaligned;
   assign o_misaligned = w_misaligned;

   // Stores are also gated by reset so a store can never land while reset is held.
   assign w_store   = i_lsu_wren && w_access_ok && !i_reset;
   assign w_dmem_we = w_store && (w_sel == SEL_DMEM);
   assign w_be      = byte_en(w_size, i_lsu_addr[1:0]);

   // Replicate store data so the enabled lanes always see the right bytes.
   always_comb begin
      case (w_size)
         SIZE_BYTE: w_wdata = {4{i_st_data[7:0]}};
         SIZE_HALF: w_wdata = {2{i_st_data[15:0]}};
         default:   w_wdata = i_st_data;
      endcase
   end

   // Address decode; DMEM is everything below DMEM_BYTES.
   always_comb begin
      w_sel = SEL_NONE;
      if ((i_lsu_addr >> AW) == 32'd0) begin
         w_sel = SEL_DMEM;
      end else begin
         case (i_lsu_addr[31:12])
            PAGE_LEDR:   w_sel = SEL_LEDR;
            PAGE_LEDG:   w_sel = SEL_LEDG;
            PAGE_HEX_LO: w_sel = SEL_HEX_LO;
            PAGE_HEX_HI: w_sel = SEL_HEX_HI;
            PAGE_LCD:    w_sel = SEL_LCD;
            PAGE_SW:     w_sel = SEL_SW;
            default:     w_sel = SEL_NONE;
         endcase
      end
   end

   dmem #(.DMEM_BYTES(DMEM_BYTES), .AW(AW)) u_dmem (
      .i_clk       (i_clk),
      .i_wr_en     (w_dmem_we),
      .i_word_addr (i_lsu_addr[AW-1:2]),
      .i_be        (w_be),
      .i_wdata     (w_wdata),
      .o_rdata     (w_dmem_rdata)
   );

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ledr <= '0;
         r_ledg <= '0;
         r_lcd  <= '0;
         for (int i = 0; i < 8; i++) r_hex[i] <= '0;
      end else if (w_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               case (w_sel)
                  SEL_LEDR:   r_ledr[8*i +: 8] <= w_wdata[8*i +: 8];
                  SEL_LEDG:   r_ledg[8*i +: 8] <= w_wdata[8*i +: 8];
                  SEL_LCD:    r_lcd[8*i +: 8]  <= w_wdata[8*i +: 8];
                  SEL_HEX_LO: r_hex[i]         <= w_wdata[8*i +: 7];
                  SEL_HEX_HI: r_hex[i+4]       <= w_wdata[8*i +: 7];
                  default:    ;
               endcase
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_sw_meta <= '0;
         r_sw_sync <= '0;
      end else begin
         r_sw_meta <= i_io_sw;
         r_sw_sync <= r_sw_meta;
      end
   end

   // Read-word mux; HEX lanes read back with bit 7 forced to 0.
   always_comb begin
      case (w_sel)
         SEL_DMEM:   w_rword = w_dmem_rdata;
         SEL_LEDR:   w_rword = r_ledr;
         SEL_LEDG:   w_rword = r_ledg;
         SEL_LCD:    w_rword = r_lcd;
         SEL_HEX_LO: w_rword = {1'b0, r_hex[3], 1'b0, r_hex[2], 1'b0, r_hex[1], 1'b0, r_hex[0]};
         SEL_HEX_HI: w_rword = {1'b0, r_hex[7], 1'b0, r_hex[6], 1'b0, r_hex[5], 1'b0, r_hex[4]};
         SEL_SW:     w_rword = r_sw_sync;
         default:    w_rword = '0;
      endcase
   end

   assign w_lane = 16'(w_rword >> {i_lsu_addr[1:0], 3'b000});

   // funct3[2] distinguishes the zero-extending variants.
   always_comb begin
      w_ld = '0;
      if (w_access_ok) begin
         case (w_size)
            SIZE_BYTE: w_ld = i_funct3[2] ? {24'd0, w_lane[7:0]} : {{24{w_lane[7]}}, w_lane[7:0]};
            SIZE_HALF: w_ld = i_funct3[2] ? {16'd0, w_lane}      : {{16{w_lane[15]}}, w_lane};
            SIZE_WORD: w_ld = w_rword;
            default:   w_ld = '0;
         endcase
      end
   end

   assign o_ld_data = w_ld;
   assign o_io_ledr = r_ledr;
   assign o_io_ledg = r_ledg;
   assign o_io_lcd  = r_lcd;
   assign o_io_hex0 = r_hex[0];
   assign o_io_hex1 = r_hex[1];
   assign o_io_hex2 = r_hex[2];
   assign o_io_hex3 = r_hex[3];
   assign o_io_hex4 = r_hex[4];
   assign o_io_hex5 = r_hex[5];
   assign o_io_hex6 = r_hex[6];
   assign o_io_hex7 = r_hex[7];

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

   localparam int MEMB = 8192;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_lsu_addr;
   logic [31:0] i_st_data;
   logic        i_lsu_wren;
   logic [2:0]  i_funct3;
   logic [31:0] o_ld_data;
   logic        o_misaligned;
   logic [31:0] i_io_sw;
   logic [31:0] o_io_ledr, o_io_ledg, o_io_lcd;
   logic [6:0]  o_io_hex0, o_io_hex1, o_io_hex2, o_io_hex3;
   logic [6:0]  o_io_hex4, o_io_hex5, o_io_hex6, o_io_hex7;

   always #5 clk = ~clk;

   lsu #(.DMEM_BYTES(MEMB)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
      .i_lsu_wren(i_lsu_wren), .i_funct3(i_funct3), .o_ld_data(o_ld_data),
      .o_misaligned(o_misaligned), .i_io_sw(i_io_sw), .o_io_ledr(o_io_ledr),
      .o_io_ledg(o_io_ledg), .o_io_hex0(o_io_hex0), .o_io_hex1(o_io_hex1),
      .o_io_hex2(o_io_hex2), .o_io_hex3(o_io_hex3), .o_io_hex4(o_io_hex4),
      .o_io_hex5(o_io_hex5), .o_io_hex6(o_io_hex6), .o_io_hex7(o_io_hex7),
      .o_io_lcd(o_io_lcd)
   );

   // Reference model: byte-addressed memory plus IO register images.
   logic [7:0]  m_mem [MEMB];
   logic [31:0] m_ledr, m_ledg, m_lcd, m_sw;
   logic [6:0]  m_hex [8];

   logic [32:0] exp_q [$];
   logic        chk;
   int          total = 0;
   int          bad   = 0;

   function automatic void m_clear_io();
      m_ledr = 0; m_ledg = 0; m_lcd = 0; m_sw = 0;
      for (int i = 0; i < 8; i++) m_hex[i] = 0;
   endfunction

   // Access width in bytes and signedness; 0 width means illegal funct3.
   function automatic int f3_bytes(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         3'b010:         return 4;
         default:        return 0;
      endcase
   endfunction

   function automatic logic [7:0] m_rd_byte(input logic [31:0] a);
      int lane;
      lane = int'(a % 4);
      if (a < MEMB) return m_mem[a];
      case (a[31:12])
         20'h10000: return m_ledr[8*lane +: 8];
         20'h10001: return m_ledg[8*lane +: 8];
         20'h10002: return {1'b0, m_hex[lane]};
         20'h10003: return {1'b0, m_hex[lane+4]};
         20'h10004: return m_lcd[8*lane +: 8];
         20'h10010: return m_sw[8*lane +: 8];
         default:   return 8'h00;
      endcase
   endfunction

   function automatic void m_wr_byte(input logic [31:0] a, input logic [7:0] b);
      int lane;
      lane = int'(a % 4);
      if (a < MEMB) m_mem[a] = b;
      else case (a[31:12])
         20'h10000: m_ledr[8*lane +: 8] = b;
         20'h10001: m_ledg[8*lane +: 8] = b;
         20'h10002: m_hex[lane]   = b[6:0];
         20'h10003: m_hex[lane+4] = b[6:0];
         20'h10004: m_lcd[8*lane +: 8] = b;
         default:   ;
      endcase
   endfunction

   // Expected {misaligned, load data}.
   function automatic logic [32:0] m_load(input logic [31:0] a, input logic [2:0] f3);
      int n;
      logic [31:0] v;
      n = f3_bytes(f3);
      if (n == 0) return 33'd0;
      if ((a % n) != 0) return {1'b1, 32'd0};
      v = 0;
      for (int i = 0; i < n; i++) v = v | (32'(m_rd_byte(a + i)) << (8*i));
      if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      return {1'b0, v};
   endfunction

   function automatic void m_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      int n;
      n = f3_bytes(f3);
      if (n == 0) return;
      if ((a % n) != 0) return;
      for (int i = 0; i < n; i++) m_wr_byte(a + i, d[8*i +: 8]);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic check_io(input string tag);
      check({tag, " ledr"}, o_io_ledr, m_ledr);
      check({tag, " ledg"}, o_io_ledg, m_ledg);
      check({tag, " lcd"},  o_io_lcd,  m_lcd);
      check({tag, " hex0"}, 32'(o_io_hex0), 32'(m_hex[0]));
      check({tag, " hex1"}, 32'(o_io_hex1), 32'(m_hex[1]));
      check({tag, " hex2"}, 32'(o_io_hex2), 32'(m_hex[2]));
      check({tag, " hex3"}, 32'(o_io_hex3), 32'(m_hex[3]));
      check({tag, " hex4"}, 32'(o_io_hex4), 32'(m_hex[4]));
      check({tag, " hex5"}, 32'(o_io_hex5), 32'(m_hex[5]));
      check({tag, " hex6"}, 32'(o_io_hex6), 32'(m_hex[6]));
      check({tag, " hex7"}, 32'(o_io_hex7), 32'(m_hex[7]));
   endtask

   // Monitor: whenever an access is presented, pop and compare the load response.
   always @(negedge clk) begin
      if (chk) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL load: response with empty expected queue, got %h", o_ld_data);
         end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({o_misaligned, o_ld_data} !== e) begin
               bad++;
               $display("FAIL load @%h f3=%b: got mis=%b data=%h want mis=%b data=%h",
                        i_lsu_addr, i_funct3, o_misaligned, o_ld_data, e[32], e[31:0]);
            end
         end
      end
   end

   // One access cycle, starting just after a rising edge; the model commits after the edge.
   task automatic op_x(input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input bit use_c, input logic [32:0] cexp);
      i_lsu_wren = we; i_lsu_addr = a; i_st_data = d; i_funct3 = f3;
      exp_q.push_back(use_c ? cexp : m_load(a, f3));
      chk = 1'b1;
      @(posedge clk);
      if (we) m_store(a, d, f3);
      #1;
      chk = 1'b0;
      i_lsu_wren = 1'b0;
   endtask

   task automatic op(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      op_x(we, a, d, f3, 1'b0, 33'd0);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] a;
      logic [2:0]  f3;
      logic [19:0] pg;
      logic [19:0] pages [5];
      pages[0] = 20'h10000; pages[1] = 20'h10001; pages[2] = 20'h10002;
      pages[3] = 20'h10003; pages[4] = 20'h10004;

      chk = 0; i_reset = 1; i_lsu_wren = 0; i_lsu_addr = 0; i_st_data = 0;
      i_funct3 = 3'b010; i_io_sw = 0;
      m_clear_io();
      #3;
      check_io("reset");
      @(negedge clk);
      i_reset = 0;
      idle();

      // Known contents for the random working area and the top DMEM word.
      for (int i = 0; i < 64; i++) op(1'b1, 32'(4*i), $urandom, 3'b010);
      op(1'b1, 32'(MEMB-4), 32'hCAFE_F00D, 3'b010);
      op_x(1'b0, 32'(MEMB-4), 0, 3'b010, 1'b1, {1'b0, 32'hCAFE_F00D});
      op_x(1'b0, 32'(MEMB), 0, 3'b010, 1'b1, 33'd0);

      // Byte store and sign/zero-extended loads.
      op(1'b1, 32'h100, 32'h8765_4321, 3'b010);
      op(1'b1, 32'h101, 32'h0000_00AA, 3'b000);
      op_x(1'b0, 32'h100, 0, 3'b010, 1'b1, {1'b0, 32'h8765_AA21});
      op_x(1'b0, 32'h101, 0, 3'b000, 1'b1, {1'b0, 32'hFFFF_FFAA});
      op_x(1'b0, 32'h101, 0, 3'b100, 1'b1, {1'b0, 32'h0000_00AA});
      op_x(1'b0, 32'h102, 0, 3'b101, 1'b1, {1'b0, 32'h0000_8765});
      op_x(1'b0, 32'h102, 0, 3'b001, 1'b1, {1'b0, 32'hFFFF_8765});

      // Misaligned and illegal accesses, including stores that must be dropped.
      op_x(1'b0, 32'h102, 0, 3'b010, 1'b1, {1'b1, 32'h0});
      op_x(1'b1, 32'h103, 32'h1111_2222, 3'b001, 1'b1, {1'b1, 32'h0});
      op_x(1'b1, 32'h100, 32'h3333_4444, 3'b011, 1'b1, 33'd0);
      op_x(1'b0, 32'h100, 0, 3'b010, 1'b1, {1'b0, 32'h8765_AA21});

      // Same-cycle load sees old data; next-cycle load sees new.
      op_x(1'b1, 32'h104, 32'h0BAD_BEEF, 3'b010, 1'b0, 33'd0);
      op_x(1'b0, 32'h104, 0, 3'b010, 1'b1, {1'b0, 32'h0BAD_BEEF});

      // IO writes.
      op(1'b1, 32'h1000_2000, 32'h0000_003F, 3'b010);
      check("hex0 const", 32'(o_io_hex0), 32'h3F);
      check_io("hex");
      op(1'b1, 32'h1000_0000, 32'h1234_5678, 3'b010);
      check("ledr const", o_io_ledr, 32'h1234_5678);
      op_x(1'b0, 32'h1000_2000, 0, 3'b010, 1'b1, {1'b0, 32'h0000_003F});

      // Switch synchroniser latency.
      i_io_sw = 32'h0000_00FF;
      op_x(1'b0, 32'h1001_0000, 0, 3'b010, 1'b1, 33'd0);
      op_x(1'b0, 32'h1001_0000, 0, 3'b010, 1'b1, 33'd0);
      op_x(1'b0, 32'h1001_0000, 0, 3'b010, 1'b1, {1'b0, 32'h0000_00FF});
      m_sw = 32'h0000_00FF;

      // Reset between edges, with a store pending across the reset edge.
      op(1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 3'b010);
      i_lsu_wren = 1; i_lsu_addr = 32'h100; i_st_data = 32'h5555_5555; i_funct3 = 3'b010;
      #2;
      i_reset = 1;
      m_clear_io();
      #1;
      check("ledr on reset", o_io_ledr, 32'h0);
      check_io("midreset");
      @(posedge clk);
      @(negedge clk);
      i_reset = 0;
      i_lsu_wren = 0;
      idle();
      op_x(1'b0, 32'h100, 0, 3'b010, 1'b1, {1'b0, 32'h8765_AA21});
      idle();
      m_sw = 32'h0000_00FF;
      op(1'b0, 32'h1001_0000, 0, 3'b010);

      // Unmapped addresses.
      op(1'b1, 32'h2000_0000, 32'hDEAD_BEEF, 3'b010);
      check_io("unmapped");
      op_x(1'b0, 32'h2000_0000, 0, 3'b010, 1'b1, 33'd0);
      op(1'b1, 32'h1001_0000, 32'h1234_0000, 3'b010);
      op(1'b0, 32'h1001_0000, 0, 3'b010);

      // Random mix of sizes, regions and store/load.
      for (int k = 0; k < 400; k++) begin
         case ($urandom_range(0, 9))
            5, 6: begin
               pg = pages[$urandom_range(0, 4)];
               a  = {pg, 12'($urandom)};
            end
            7: a = {20'h10010, 12'($urandom)};
            8: a = 32'h3000_0000 + 32'($urandom_range(0, 65535));
            default: a = 32'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 9) < 8) begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000; 1: f3 = 3'b001; 2: f3 = 3'b010;
               3: f3 = 3'b100; default: f3 = 3'b101;
            endcase
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         op(1'($urandom_range(0, 1)), a, $urandom, f3);
         if ((k % 25) == 24) check_io("random");
      end

      repeat (2) @(negedge clk);
      check("queue drained", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
